// File: rtl/tinyrv_pkg.sv
// Shared encodings for the tinyrv execute slice: opcodes, funct codes, ALU operation set.
// Build option TINYRV_ILLEGAL_EN (used by tinyrv_core) adds an illegal-instruction flag.
package tinyrv_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_N  = 32;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  // Map funct3 plus the alternate-encoding bit (inst[30]) to an ALU operation.
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      F3_ADD_SUB: if (alt) op = ALU_SUB; else op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      if (alt) op = ALU_SRA; else op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/tinyrv_regfile.sv
// 32x32 integer register file: two asynchronous read ports, one write port,
// asynchronous active-low clear, x0 hardwired to zero.
module tinyrv_regfile
  import tinyrv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN_W-1:0] rs1_data_c,
  output logic [XLEN_W-1:0] rs2_data_c,
  input  logic              we,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN_W-1:0] rd_data
);

  logic [XLEN_W-1:0] regs [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we && (rd_addr != '0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data_c = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data_c = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/tinyrv_core.sv
// Single-cycle RV32I execute slice: decode, immediates, ALU, branch compare, next-pc.
// Define TINYRV_ILLEGAL_EN to add the 'illegal' output for unsupported encodings.
module tinyrv_core
  import tinyrv_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next
`ifdef TINYRV_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [XLEN_W-1:0] rs1, rs2;
  logic [XLEN_W-1:0] imm_i, imm_b, imm_u, imm_j;
  logic [XLEN_W-1:0] alu_a, alu_b, alu_y;
  alu_op_t           alu_op;
  logic              legal_c, writes_rd, is_jal, is_jalr, is_branch, is_link;
  logic              rd_we_c, br_taken;
  logic [XLEN_W-1:0] pc_plus4, jalr_sum, rd_data, npc;

  assign opcode   = inst[6:0];
  assign rd_addr  = inst[11:7];
  assign funct3   = inst[14:12];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign funct7   = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  tinyrv_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data_c (rs1),
    .rs2_data_c (rs2),
    .we         (rd_we_c),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  // Decoder: unknown or unlisted encodings fall through to a no-op.
  always_comb begin
    legal_c   = 1'b0;
    writes_rd = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    is_link   = 1'b0;
    alu_op    = ALU_ADD;
    alu_a     = rs1;
    alu_b     = rs2;
    case (opcode)
      OP_IMM: begin
        writes_rd = 1'b1;
        alu_b     = imm_i;
        alu_op    = alu_op_decode(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
        case (funct3)
          F3_SLL:  legal_c = (funct7 == F7_BASE);
          F3_SR:   legal_c = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal_c = 1'b1;
        endcase
      end
      OP: begin
        writes_rd = 1'b1;
        alu_op    = alu_op_decode(funct3, funct7 == F7_ALT);
        legal_c   = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
      end
      LUI: begin
        legal_c   = 1'b1;
        writes_rd = 1'b1;
        alu_op    = ALU_PASS_B;
        alu_b     = imm_u;
      end
      AUIPC: begin
        legal_c   = 1'b1;
        writes_rd = 1'b1;
        alu_a     = pc;
        alu_b     = imm_u;
      end
      JAL: begin
        legal_c   = 1'b1;
        writes_rd = 1'b1;
        is_jal    = 1'b1;
        is_link   = 1'b1;
      end
      JALR: begin
        legal_c   = (funct3 == 3'b000);
        writes_rd = 1'b1;
        is_jalr   = 1'b1;
        is_link   = 1'b1;
      end
      BRANCH: begin
        legal_c   = (funct3 != 3'b010) && (funct3 != 3'b011);
        is_branch = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_we_c = legal_c & writes_rd;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:    alu_y = alu_a + alu_b;
      ALU_SUB:    alu_y = alu_a - alu_b;
      ALU_SLL:    alu_y = alu_a << alu_b[4:0];
      ALU_SLT:    alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   alu_y = {31'b0, alu_a < alu_b};
      ALU_XOR:    alu_y = alu_a ^ alu_b;
      ALU_SRL:    alu_y = alu_a >> alu_b[4:0];
      ALU_SRA:    alu_y = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:     alu_y = alu_a | alu_b;
      ALU_AND:    alu_y = alu_a & alu_b;
      ALU_PASS_B: alu_y = alu_b;
      default:    alu_y = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1 == rs2);
      F3_BNE:  br_taken = (rs1 != rs2);
      F3_BLT:  br_taken = ($signed(rs1) < $signed(rs2));
      F3_BGE:  br_taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: br_taken = (rs1 < rs2);
      F3_BGEU: br_taken = (rs1 >= rs2);
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign jalr_sum = rs1 + imm_i;
  assign rd_data  = is_link ? pc_plus4 : alu_y;

  // Misaligned targets pass through untouched; only JALR clears bit 0.
  always_comb begin
    npc = pc_plus4;
    if (legal_c && is_jal) begin
      npc = pc + imm_j;
    end else if (legal_c && is_jalr) begin
      npc = {jalr_sum[31:1], 1'b0};
    end else if (legal_c && is_branch && br_taken) begin
      npc = pc + imm_b;
    end
  end

  assign pc_next = rst_n ? npc : RESET_PC;

`ifdef TINYRV_ILLEGAL_EN
  assign illegal = rst_n & ~legal_c;
`endif

endmodule

// File: tb/tb_tinyrv_core.sv
// Self-checking bench for tinyrv_core: directed scenarios plus random instructions
// compared against an instruction-level reference model of the RV32I subset.
module tb_tinyrv_core;

  localparam logic [6:0] O_OPIMM = 7'h13, O_OP = 7'h33, O_LUI = 7'h37, O_AUIPC = 7'h17;
  localparam logic [6:0] O_JAL = 7'h6f, O_JALR = 7'h67, O_BR = 7'h63;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_next;
`ifdef TINYRV_ILLEGAL_EN
  logic        illegal;
`endif

  int n_checks;
  int n_errors;
  logic [31:0] mregs [32];
  logic [6:0]  opcs [11] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                             7'h03, 7'h23, 7'h0f, 7'h73};

  tinyrv_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inst    (inst),
    .pc      (pc),
    .pc_next (pc_next)
`ifdef TINYRV_ILLEGAL_EN
    ,
    .illegal (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, O_OP};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], O_BR};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: if (alt) return a - b; else return a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: if (alt) return sa >>> b[4:0]; else return a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit taken_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  // Instruction-level reference: architectural effect of one instruction.
  function automatic void model_exec(input logic [31:0] i, input logic [31:0] p,
                                     output bit we, output logic [4:0] rd,
                                     output logic [31:0] wd, output logic [31:0] npc,
                                     output bit ok);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, imm_i, imm_b, imm_j, imm_u;
    opc   = i[6:0];
    f3    = i[14:12];
    f7    = i[31:25];
    rd    = i[11:7];
    a     = mregs[i[19:15]];
    b     = mregs[i[24:20]];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    imm_u = {i[31:12], 12'h000};
    we  = 1'b0;
    ok  = 1'b1;
    wd  = 32'h0;
    npc = p + 32'd4;
    case (opc)
      O_OPIMM: begin
        if (f3 == 3'd1)      ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        we = ok;
        wd = alu_ref(f3, (f3 == 3'd5) && (f7 == 7'h20), a, imm_i);
      end
      O_OP: begin
        ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        we = ok;
        wd = alu_ref(f3, f7 == 7'h20, a, b);
      end
      O_LUI:   begin we = 1'b1; wd = imm_u; end
      O_AUIPC: begin we = 1'b1; wd = p + imm_u; end
      O_JAL:   begin we = 1'b1; wd = p + 32'd4; npc = p + imm_j; end
      O_JALR: begin
        ok = (f3 == 3'd0);
        we = ok;
        wd = p + 32'd4;
        if (ok) npc = (a + imm_i) & ~32'h1;
      end
      O_BR: begin
        ok = (f3 != 3'd2) && (f3 != 3'd3);
        if (ok && taken_ref(f3, a, b)) npc = p + imm_b;
      end
      default: ok = 1'b0;
    endcase
  endfunction

  // Present one instruction, check combinational results, then let it retire.
  task automatic run_instr(input logic [31:0] i, input logic [31:0] p, output logic [31:0] npc_obs);
    bit we, ok;
    logic [4:0]  rd;
    logic [31:0] wd, npc;
    @(negedge clk);
    inst = i;
    pc   = p;
    #1;
    model_exec(i, p, we, rd, wd, npc, ok);
    npc_obs = pc_next;
    check_eq($sformatf("pc_next inst=%h pc=%h", i, p), pc_next, npc);
`ifdef TINYRV_ILLEGAL_EN
    check_eq($sformatf("illegal inst=%h", i), 32'(illegal), 32'(!ok));
`endif
    @(posedge clk);
    if (we && (rd != 5'd0)) mregs[rd] = wd;
  endtask

  task automatic exec(input logic [31:0] i);
    logic [31:0] dummy;
    run_instr(i, 32'h0, dummy);
  endtask

  // Observe a register through two jalr x0 probes (bit 0 recovered from the +1 probe).
  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    logic [31:0] n0, n1;
    run_instr(enc_i(12'd0, r, 3'd0, 5'd0, O_JALR), 32'h0, n0);
    run_instr(enc_i(12'd1, r, 3'd0, 5'd0, O_JALR), 32'h0, n1);
    v = (n1 == n0) ? n0 : n0 + 32'd1;
  endtask

  task automatic check_all_regs(input string tag);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) begin
      read_reg(5'(r), v);
      check_eq($sformatf("%s x%0d", tag, r), v, mregs[r]);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    int k;
    i = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) i[6:0] = opcs[k];
    case (i[6:0])
      O_OP:
        if ($urandom_range(0, 3) != 0) i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
      O_OPIMM:
        if ((i[14:12] == 3'd1) && ($urandom_range(0, 3) != 0)) i[31:25] = 7'h00;
        else if ((i[14:12] == 3'd5) && ($urandom_range(0, 3) != 0))
          i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
      O_JALR:
        if ($urandom_range(0, 3) != 0) i[14:12] = 3'd0;
      O_BR:
        if ($urandom_range(0, 2) == 0) i[24:20] = i[19:15];
      default: ;
    endcase
    return i;
  endfunction

  initial begin
    logic [31:0] v, n;
    n_checks = 0;
    n_errors = 0;
    for (int r = 0; r < 32; r++) mregs[r] = 32'h0;

    // Reset state
    rst_n = 1'b0;
    inst  = enc_i(12'd5, 5'd0, 3'd0, 5'd1, O_OPIMM);
    pc    = 32'h1000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pc_next in reset", pc_next, 32'h0);
    @(negedge clk);
    inst  = 32'h0;
    rst_n = 1'b1;
    check_all_regs("after reset");

    // addi x1,x0,8 ; addi x0,x1,0
    run_instr(32'h00800093, 32'h0, n);
    check_eq("addi pc_next", n, 32'h4);
    read_reg(5'd1, v);
    check_eq("addi x1", v, 32'd8);
    exec(32'h00008013);
    read_reg(5'd0, v);
    check_eq("x0 write", v, 32'h0);
    check_all_regs("after x0 write");

    // beq taken / not taken
    exec(enc_i(12'd8, 5'd0, 3'd0, 5'd2, O_OPIMM));
    run_instr(enc_b(13'd16, 5'd2, 5'd1, 3'd0), 32'h100, n);
    check_eq("beq taken", n, 32'h110);
    exec(enc_i(12'hFFF, 5'd2, 3'd0, 5'd2, O_OPIMM));
    run_instr(enc_b(13'd16, 5'd2, 5'd1, 3'd0), 32'h100, n);
    check_eq("beq not taken", n, 32'h104);

    // jalr x5,8(x1) ; lui x3,0xABCDE
    run_instr(enc_i(12'd8, 5'd1, 3'd0, 5'd5, O_JALR), 32'h40, n);
    check_eq("jalr target", n, 32'h10);
    read_reg(5'd5, v);
    check_eq("jalr link x5", v, 32'h44);
    exec({20'hABCDE, 5'd3, O_LUI});
    read_reg(5'd3, v);
    check_eq("lui x3", v, 32'hABCDE000);

    // srai / sltu / add wrap / sub
    exec(enc_i(12'hFF8, 5'd0, 3'd0, 5'd1, O_OPIMM));
    exec(enc_i({7'h20, 5'd1}, 5'd1, 3'd5, 5'd4, O_OPIMM));
    read_reg(5'd4, v);
    check_eq("srai x4", v, 32'hFFFFFFFC);
    exec(enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd6));
    read_reg(5'd6, v);
    check_eq("sltu x6", v, 32'd1);
    exec(enc_i(12'hFFF, 5'd0, 3'd0, 5'd7, O_OPIMM));
    exec(enc_i(12'd1, 5'd0, 3'd0, 5'd8, O_OPIMM));
    exec(enc_r(7'h00, 5'd8, 5'd7, 3'd0, 5'd9));
    read_reg(5'd9, v);
    check_eq("add wrap x9", v, 32'h0);
    exec(enc_r(7'h20, 5'd8, 5'd1, 3'd0, 5'd10));
    read_reg(5'd10, v);
    check_eq("sub x10", v, 32'hFFFFFFF7);

    // Unsupported encodings: no write, pc+4
    run_instr(32'hFFFFFFFF, 32'h200, n);
    check_eq("unsupported pc_next", n, 32'h204);
    exec(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd12));
    check_all_regs("after unsupported");

    // Asynchronous reset pulse between edges
    #2;
    rst_n = 1'b0;
    inst  = 32'hFFFFFFFF;
    pc    = 32'h300;
    #1;
    check_eq("pc_next async reset", pc_next, 32'h0);
`ifdef TINYRV_ILLEGAL_EN
    check_eq("illegal in reset", 32'(illegal), 32'h0);
`endif
    #1;
    inst  = 32'h0;
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) mregs[r] = 32'h0;
    check_all_regs("after async reset");

    // Writes blocked while reset is held across an edge
    @(negedge clk);
    rst_n = 1'b0;
    inst  = enc_i(12'd5, 5'd0, 3'd0, 5'd11, O_OPIMM);
    @(posedge clk);
    @(negedge clk);
    inst  = 32'h0;
    rst_n = 1'b1;
    read_reg(5'd11, v);
    check_eq("write during reset x11", v, 32'h0);

    // Random instruction stream
    for (int t = 0; t < 600; t++) begin
      run_instr(rand_instr(), $urandom & 32'hFFFF_FFFC, n);
      if ((t % 200) == 199) check_all_regs("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
